// File: rtl/aud_btm_tx.sv
// aud_btm_tx -- AUD branch-trace transmitter.
//
// Takes 32-bit branch destination addresses from a valid/ready handshake and
// serialises them as AUD frames: a START symbol carrying the compression mode,
// followed by 1, 2, 4 or 8 address nibbles, LSB nibble first. SYNC is driven
// whenever no frame is in progress. Addresses are compressed against the last
// fully transmitted address, matching the AUD branch-trace receiver.
//
// Parameters
//   PREEMPT    1: a pending address aborts the frame in progress
//   FORCE_FULL 1: always send mode 3 (8 nibbles)
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   br_addr      branch address, sampled when br_valid & br_ready
//   br_valid     address offered
//   br_ready     one-entry holding register is empty
//   aud_ck       AUD clock, clk/2
//   aud_nsync    1 = SYNC/START symbol, 0 = address nibble
//   aud_data     AUD symbol
//   busy         frame in progress or holding register full
//   frame_done   one-clk pulse as the last nibble of a frame is driven
//   frame_abort  one-clk pulse as a preempting START is driven
//
// state    | meaning
// ---------+-------------------------------------------
// ST_IDLE  | SYNC on the bus, no frame in progress
// ST_START | START symbol on the bus
// ST_DATA  | address nibble on the bus
module aud_btm_tx #(
    parameter bit PREEMPT    = 1'b0,
    parameter bit FORCE_FULL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] br_addr,
    input  logic        br_valid,
    output logic        br_ready,
    output logic        aud_ck,
    output logic        aud_nsync,
    output logic [3:0]  aud_data,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_abort
);

    localparam logic [3:0] SYNC_SYM = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA
    } state_t;

    state_t      state_q, state_d;
    logic        ph_q;
    logic        hold_full_q, hold_full_d;
    logic [31:0] hold_addr_q, hold_addr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] last_q, last_d;
    logic [3:0]  cnt_q, cnt_d;      // nibbles of the current frame still to drive
    logic [2:0]  idx_q, idx_d;      // index of the next nibble to drive
    logic        nsync_q, nsync_d;
    logic [3:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        abort_q, abort_d;

    logic        bnd;
    logic        accept;
    logic        take;
    logic        load;
    logic        drive;
    logic [1:0]  new_mode;
    logic [3:0]  nib;

    // Symbols change only on the edge where ph rises, i.e. when ph is still 0.
    assign bnd    = ~ph_q;
    assign accept = br_valid & ~hold_full_q;
    assign nib    = addr_q[{idx_q, 2'b00} +: 4];

    always_comb begin
        new_mode = 2'd3;
        if (!FORCE_FULL) begin
            if (hold_addr_q[31:4] == last_q[31:4])
                new_mode = 2'd0;
            else if (hold_addr_q[31:8] == last_q[31:8])
                new_mode = 2'd1;
            else if (hold_addr_q[31:16] == last_q[31:16])
                new_mode = 2'd2;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        nsync_d = nsync_q;
        data_d  = data_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        take    = 1'b0;
        load    = 1'b0;
        drive   = 1'b0;

        if (bnd) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (hold_full_q) begin
                        load = 1'b1;
                    end else begin
                        nsync_d = 1'b1;
                        data_d  = SYNC_SYM;
                    end
                end
                ST_START: drive = 1'b1;
                ST_DATA: begin
                    if (cnt_q == 4'd0) begin
                        if (hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            nsync_d = 1'b1;
                            data_d  = SYNC_SYM;
                        end
                    end else if (PREEMPT && hold_full_q) begin
                        // last_q is left alone: the receiver reverts to it.
                        abort_d = 1'b1;
                        load    = 1'b1;
                    end else begin
                        drive = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    nsync_d = 1'b1;
                    data_d  = SYNC_SYM;
                end
            endcase
        end

        if (drive) begin
            state_d = ST_DATA;
            nsync_d = 1'b0;
            data_d  = nib;
            idx_d   = idx_q + 3'd1;
            cnt_d   = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                done_d = 1'b1;
                last_d = addr_q;
            end
        end

        if (load) begin
            take    = 1'b1;
            state_d = ST_START;
            addr_d  = hold_addr_q;
            cnt_d   = 4'd1 << new_mode;
            idx_d   = 3'd0;
            nsync_d = 1'b1;
            data_d  = {2'b10, new_mode};
        end
    end

    // take implies the register was already full, so accept and take never
    // coincide; the accept term still wins if they ever did.
    assign hold_full_d = accept | (hold_full_q & ~take);
    assign hold_addr_d = accept ? br_addr : hold_addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ph_q        <= 1'b0;
            hold_full_q <= 1'b0;
            hold_addr_q <= '0;
            addr_q      <= '0;
            last_q      <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            nsync_q     <= 1'b1;
            data_q      <= SYNC_SYM;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ~ph_q;
            hold_full_q <= hold_full_d;
            hold_addr_q <= hold_addr_d;
            addr_q      <= addr_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            nsync_q     <= nsync_d;
            data_q      <= data_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
        end
    end

    assign aud_ck      = ph_q;
    assign aud_nsync   = nsync_q;
    assign aud_data    = data_q;
    assign br_ready    = ~hold_full_q;
    assign busy        = (state_q != ST_IDLE) | hold_full_q;
    assign frame_done  = done_q;
    assign frame_abort = abort_q;

endmodule

// File: tb/tb_aud_btm_tx.sv
module tb_aud_btm_tx;

    typedef struct {
        logic       nsync;
        logic [3:0] data;
        logic       done;
        logic       abort;
        logic       no_gap;   // a SYNC seen while this entry is next is an error
    } sym_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] br_addr = '0;
    logic        valid_v [3];
    logic        ready_w [3];
    logic        ck_w    [3];
    logic        nsync_w [3];
    logic [3:0]  data_w  [3];
    logic        busy_w  [3];
    logic        done_w  [3];
    logic        abort_w [3];

    int   total = 0;
    int   bad   = 0;
    int   pops  = 0;
    int   sel   = 0;
    int   base  = 0;
    sym_t exp_q[$];
    sym_t e;

    always #5 clk = ~clk;

    // 0: default, 1: PREEMPT, 2: FORCE_FULL
    for (genvar g = 0; g < 3; g++) begin : gen_dut
        aud_btm_tx #(
            .PREEMPT    (g == 1),
            .FORCE_FULL (g == 2)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .br_addr     (br_addr),
            .br_valid    (valid_v[g]),
            .br_ready    (ready_w[g]),
            .aud_ck      (ck_w[g]),
            .aud_nsync   (nsync_w[g]),
            .aud_data    (data_w[g]),
            .busy        (busy_w[g]),
            .frame_done  (done_w[g]),
            .frame_abort (abort_w[g])
        );
    end

    // Monitor: aud_ck is high for exactly one clk per symbol, so each falling
    // clk edge with aud_ck high samples one symbol.
    always @(negedge clk) begin
        if (!rst) begin
            if (ck_w[sel]) begin
                if (nsync_w[sel] && data_w[sel] == 4'b0011) begin
                    if (exp_q.size() > 0 && exp_q[0].no_gap) begin
                        total++;
                        bad++;
                        $display("FAIL gap: got SYNC, required nsync=%0b data=%h",
                                 exp_q[0].nsync, exp_q[0].data);
                        void'(exp_q.pop_front());
                        pops++;
                    end
                end else begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL extra_symbol: got nsync=%0b data=%h, required none",
                                 nsync_w[sel], data_w[sel]);
                    end else begin
                        e = exp_q.pop_front();
                        pops++;
                        if (nsync_w[sel] !== e.nsync || data_w[sel] !== e.data ||
                            done_w[sel] !== e.done || abort_w[sel] !== e.abort) begin
                            bad++;
                            $display("FAIL symbol: got nsync=%0b data=%h done=%0b abort=%0b, required nsync=%0b data=%h done=%0b abort=%0b",
                                     nsync_w[sel], data_w[sel], done_w[sel], abort_w[sel],
                                     e.nsync, e.data, e.done, e.abort);
                        end
                    end
                end
            end else begin
                total++;
                if (done_w[sel] !== 1'b0 || abort_w[sel] !== 1'b0) begin
                    bad++;
                    $display("FAIL pulse_width: got done=%0b abort=%0b, required 0 0",
                             done_w[sel], abort_w[sel]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    task automatic push_sym(input logic n, input logic [3:0] d, input logic dn,
                            input logic ab, input logic gap);
        sym_t s;
        s.nsync  = n;
        s.data   = d;
        s.done   = dn;
        s.abort  = ab;
        s.no_gap = gap;
        exp_q.push_back(s);
    endtask

    task automatic push_frame(input logic [31:0] a, input logic [1:0] mode,
                              input logic gap, input logic ab);
        int n;
        n = 1 << mode;
        push_sym(1'b1, {2'b10, mode}, 1'b0, ab, gap);
        for (int i = 0; i < n; i++)
            push_sym(1'b0, a[4*i +: 4], (i == n - 1), 1'b0, 1'b1);
    endtask

    task automatic offer(input int s, input logic [31:0] a);
        int n;
        n = 0;
        while (!ready_w[s] && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!ready_w[s]) begin
            total++;
            bad++;
            $display("FAIL offer_timeout: got br_ready=0, required 1");
            return;
        end
        br_addr    = a;
        valid_v[s] = 1'b1;
        @(posedge clk);
        #1;
        valid_v[s] = 1'b0;
    endtask

    task automatic wait_pops(input int target);
        int n;
        n = 0;
        while (pops < target && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (pops < target) begin
            total++;
            bad++;
            $display("FAIL pops_timeout: got %0d symbols, required %0d", pops, target);
            exp_q.delete();
        end
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d symbols outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) valid_v[i] = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ck",    {31'd0, ck_w[0]},    32'd0);
        check("rst_nsync", {31'd0, nsync_w[0]}, 32'd1);
        check("rst_data",  {28'd0, data_w[0]},  32'h3);
        check("rst_ready", {31'd0, ready_w[0]}, 32'd1);
        check("rst_busy",  {31'd0, busy_w[0]},  32'd0);
        check("rst_done",  {31'd0, done_w[0]},  32'd0);
        check("rst_abort", {31'd0, abort_w[0]}, 32'd0);
        rst = 1'b0;

        // Single mode-0 frame, then the bus returns to SYNC.
        sel = 0;
        push_frame(32'h0000_0005, 2'd0, 1'b0, 1'b0);
        offer(0, 32'h0000_0005);
        wait_empty();
        repeat (4) @(negedge clk);
        check("idle_nsync", {31'd0, nsync_w[0]}, 32'd1);
        check("idle_data",  {28'd0, data_w[0]},  32'h3);
        check("idle_busy",  {31'd0, busy_w[0]},  32'd0);

        // Compression against the previous address.
        push_frame(32'h0000_1234, 2'd2, 1'b0, 1'b0);
        offer(0, 32'h0000_1234);
        wait_empty();
        push_frame(32'h0000_1238, 2'd0, 1'b0, 1'b0);
        offer(0, 32'h0000_1238);
        wait_empty();

        // Back-to-back full frames with no SYNC between them.
        push_frame(32'h8000_ABCD, 2'd3, 1'b0, 1'b0);
        push_frame(32'h7000_ABCD, 2'd3, 1'b1, 1'b0);
        offer(0, 32'h8000_ABCD);
        check("b2b_ready_low", {31'd0, ready_w[0]}, 32'd0);
        check("b2b_busy",      {31'd0, busy_w[0]},  32'd1);
        offer(0, 32'h7000_ABCD);
        wait_empty();

        // Preemption after two nibbles.
        repeat (4) @(negedge clk);
        sel  = 1;
        base = pops;
        push_sym(1'b1, 4'b1011, 1'b0, 1'b0, 1'b0);
        push_sym(1'b0, 4'hF,    1'b0, 1'b0, 1'b1);
        push_sym(1'b0, 4'hE,    1'b0, 1'b0, 1'b1);
        push_sym(1'b1, 4'b1000, 1'b0, 1'b1, 1'b1);
        push_sym(1'b0, 4'h1,    1'b1, 1'b0, 1'b1);
        offer(1, 32'hDEAD_BEEF);
        wait_pops(base + 3);
        offer(1, 32'h0000_0001);
        wait_empty();

        // Forced full frame of a zero address.
        repeat (4) @(negedge clk);
        sel = 2;
        push_frame(32'h0000_0000, 2'd3, 1'b0, 1'b0);
        offer(2, 32'h0000_0000);
        wait_empty();

        // Reset in the middle of a frame.
        repeat (4) @(negedge clk);
        sel  = 0;
        base = pops;
        push_frame(32'h1234_5678, 2'd3, 1'b0, 1'b0);
        offer(0, 32'h1234_5678);
        wait_pops(base + 3);
        rst = 1'b1;
        #1;
        check("mid_rst_ck",    {31'd0, ck_w[0]},    32'd0);
        check("mid_rst_nsync", {31'd0, nsync_w[0]}, 32'd1);
        check("mid_rst_data",  {28'd0, data_w[0]},  32'h3);
        check("mid_rst_ready", {31'd0, ready_w[0]}, 32'd1);
        check("mid_rst_busy",  {31'd0, busy_w[0]},  32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // last_addr was cleared, so 0x10 compresses to mode 1.
        push_frame(32'h0000_0010, 2'd1, 1'b0, 1'b0);
        offer(0, 32'h0000_0010);
        wait_empty();
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aud_btm_tx.md
# aud_btm_tx

Branch-trace transmitter for the AUD interface: accepts 32-bit branch destination addresses from a parallel handshake and serialises them onto aud_ck / aud_nsync / aud_data[3:0]. It uses the same framing and address compression that our AUD branch-trace receiver decodes. It is used as the trace source in loopback benches and as a target-side emulator in the FPGA build.

## Interface
Parameters:
- PREEMPT, 0, 1 = a new address aborts a frame in progress; 0 = the new address waits until the frame completes.
- FORCE_FULL, 0, 1 = always send mode 3 (8 nibbles) and disable compression.

Ports:
- clk  in  1  system clock; all state changes on posedge clk.
- rst  in  1  reset, asynchronous, active-high.
- br_addr  in  32  branch address; sampled on the accept cycle.
- br_valid  in  1  address offered.
- br_ready  out  1  holding register empty; accept = br_valid & br_ready.
- aud_ck  out  1  AUD clock, clk/2.
- aud_nsync  out  1  1 = sync/start symbol, 0 = address nibble.
- aud_data  out  4  AUD symbol.
- busy  out  1  frame in progress or holding register full.
- frame_done  out  1  one-clk pulse when the last nibble of a frame is driven.
- frame_abort  out  1  one-clk pulse when PREEMPT cuts a frame short.

## Operation
- Symbols:
  - SYNC: nsync=1, data=4'b0011.
  - START: nsync=1, data={2'b10, mode}.
  - NIBBLE: nsync=0, data=addr nibble, LSB nibble first.
  - Frame = START followed by exactly 1<<mode NIBBLE symbols (1, 2, 4 or 8).
- Compression is measured against last_addr, the last fully transmitted address (reset 0):
  - mode 0 if addr[31:4] == last_addr[31:4].
  - mode 1 if addr[31:8] matches.
  - mode 2 if addr[31:16] matches.
  - mode 3 otherwise, or whenever FORCE_FULL=1.
  - The smallest qualifying mode is always chosen.
- Holding register: one entry. br_ready = ~hold_full. Accepting an address sets hold_full; the FSM taking the address clears it. If both happen in the same clk, hold_full remains 1.
- FSM states (each state is the symbol currently on the bus), evaluated at each symbol boundary:
  - IDLE: if hold_full, go to START, latch the address into shift_reg, compute mode, cnt = 1<<mode. Otherwise stay in IDLE (drive SYNC).
  - START: go to DATA, drive nibble 0.
  - DATA, more nibbles remaining: drive the next nibble, cnt-1.
  - DATA, last nibble driven: frame_done, last_addr <= shift_reg. Next boundary goes to START if hold_full (back-to-back, no SYNC between frames), else IDLE.
  - DATA with PREEMPT=1 and hold_full before the last nibble: frame_abort, go to START with the new address. last_addr is unchanged, matching the receiver's revert-to-last-good rule.
  - With PREEMPT=0, a pending address never affects the frame in progress.
- busy = (state != IDLE) | hold_full.

## Timing
- ph toggles every clk and aud_ck = ph; reset value 0.
- Symbol boundary = the clk edge where ph goes 0 -> 1. aud_nsync and aud_data update only there, so they change on aud_ck rising edges and are stable a half period before the receiver samples on the falling edge.
- One symbol lasts 2 clk.
- Latency: br_valid accepted while IDLE puts START on the bus at the next boundary, 1-2 clk later.
- frame_done and frame_abort are asserted in the clk of the boundary that drives the last nibble or the aborting START.
- Reset values: aud_ck=0, aud_nsync=1, aud_data=4'b0011, br_ready=1, busy=0, frame_done=0, frame_abort=0. Internally: state IDLE, hold_full=0, last_addr=0.
- Reset mid-frame: the bus returns to SYNC immediately (asynchronously), and the pending address and last_addr are discarded.
- Mode arithmetic is a pure compare on the upper bits; there is no subtraction and no wrap-around case.

## Test plan
- Reset, then 0x00000005 -> START 4'b1000, one nibble 5, then SYNC. frame_done fires once, last_addr=0x00000005.
- Then 0x00001234, then 0x00001238 -> first frame uses mode 2: nibbles 4,3,2,1. Second frame uses mode 0: one nibble 8.
- 0x8000ABCD, then 0x7000ABCD presented back-to-back -> two mode 3 frames of 8 nibbles each, no SYNC between them. br_ready drops while hold_full=1.
- PREEMPT=1: start 0xDEADBEEF (mode 3) and inject 0x00000001 after nibble 2 -> frame_abort pulse, then START 4'b1000 with nibble 1, since last_addr is still 0.
- FORCE_FULL=1: send 0x00000000 -> START 4'b1011 followed by 8 zero nibbles.
- Assert rst mid-frame -> outputs return to reset values within the same clk, br_ready=1. The next frame is compressed against 0.
